// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int RF_AW        = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_rs1_read,
  input  logic [RF_AW-1:0] id_rs1_addr,
  input  logic             id_rs2_read,
  input  logic [RF_AW-1:0] id_rs2_addr,
  input  logic             ex_mem_rd,
  input  logic             ex_reg_wen,
  input  logic [RF_AW-1:0] ex_reg_waddr,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             bubble_ex,
  output logic             flush_id,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt,
`endif
  output logic [1:0]       ctrl_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    ILLEGAL  = 2'd3
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic lu;
  logic rs1_hit, rs2_hit;
  logic s_if, s_id, s_ex, s_mem, bub, fl;

  assign rs1_hit = id_rs1_read & (id_rs1_addr == ex_reg_waddr);
  assign rs2_hit = id_rs2_read & (id_rs2_addr == ex_reg_waddr);
  assign lu = id_valid & ex_mem_rd & ex_reg_wen
            & (ex_reg_waddr != '0) & (rs1_hit | rs2_hit);

  // State and flush counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and raw pipeline control; MEM_WAIT decides like RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_if    = 1'b0;
    s_id    = 1'b0;
    s_ex    = 1'b0;
    s_mem   = 1'b0;
    bub     = 1'b0;
    fl      = 1'b0;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (dmem_busy) begin
          {s_if, s_id, s_ex, s_mem} = 4'hF;
          state_d = MEM_WAIT;
        end else if (ex_branch_taken) begin
          fl  = 1'b1;
          bub = 1'b1;
          if (FLUSH_CYCLES == 1) begin
            state_d = RUN;
          end else begin
            state_d = FLUSH;
            cnt_d   = CNT_INIT;
          end
        end else if (lu) begin
          s_if    = 1'b1;
          s_id    = 1'b1;
          bub     = 1'b1;
          state_d = RUN;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        fl = 1'b1;
        if (dmem_busy) begin
          {s_if, s_id, s_ex, s_mem} = 4'hF;
        end else begin
          bub   = 1'b1;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign stall_if   = s_if  & ~rst;
  assign stall_id   = s_id  & ~rst;
  assign stall_ex   = s_ex  & ~rst;
  assign stall_mem  = s_mem & ~rst;
  assign bubble_ex  = bub   & ~rst;
  assign flush_id   = fl    & ~rst;
  assign ctrl_state = rst ? 2'd0 : state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  // Cycle counters for stalled and flushed fetch slots
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_if) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush_id) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: FLUSH_CYCLES=2 and =4 instances.
// Vector order: {stall_if,stall_id,stall_ex,stall_mem,bubble_ex,flush_id,ctrl_state}
module tb_pipe_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_read, id_rs2_read;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_reg_waddr;
  logic       ex_mem_rd, ex_reg_wen, ex_branch_taken, dmem_busy;

  logic       a_sif, a_sid, a_sex, a_smem, a_bub, a_fl;
  logic [1:0] a_st;
  logic       b_sif, b_sid, b_sex, b_smem, b_bub, b_fl;
  logic [1:0] b_st;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] a_ps, a_pf, b_ps, b_pf;
`endif

  logic [7:0] v2, v4;
  int n_chk = 0;
  int n_fail = 0;

  assign v2 = {a_sif, a_sid, a_sex, a_smem, a_bub, a_fl, a_st};
  assign v4 = {b_sif, b_sid, b_sex, b_smem, b_bub, b_fl, b_st};

  always #5 clk = ~clk;

  pipe_ctrl #(.RF_AW(5), .FLUSH_CYCLES(2)) u2 (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rs1_read(id_rs1_read), .id_rs1_addr(id_rs1_addr),
    .id_rs2_read(id_rs2_read), .id_rs2_addr(id_rs2_addr),
    .ex_mem_rd(ex_mem_rd), .ex_reg_wen(ex_reg_wen),
    .ex_reg_waddr(ex_reg_waddr),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .stall_if(a_sif), .stall_id(a_sid),
    .stall_ex(a_sex), .stall_mem(a_smem),
    .bubble_ex(a_bub), .flush_id(a_fl),
`ifdef PIPE_CTRL_PERF_EN
    .perf_stall_cnt(a_ps), .perf_flush_cnt(a_pf),
`endif
    .ctrl_state(a_st)
  );

  pipe_ctrl #(.RF_AW(5), .FLUSH_CYCLES(4)) u4 (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rs1_read(id_rs1_read), .id_rs1_addr(id_rs1_addr),
    .id_rs2_read(id_rs2_read), .id_rs2_addr(id_rs2_addr),
    .ex_mem_rd(ex_mem_rd), .ex_reg_wen(ex_reg_wen),
    .ex_reg_waddr(ex_reg_waddr),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .stall_if(b_sif), .stall_id(b_sid),
    .stall_ex(b_sex), .stall_mem(b_smem),
    .bubble_ex(b_bub), .flush_id(b_fl),
`ifdef PIPE_CTRL_PERF_EN
    .perf_stall_cnt(b_ps), .perf_flush_cnt(b_pf),
`endif
    .ctrl_state(b_st)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input bit use4,
                     input logic [7:0] exp,
                     input logic [7:0] msk);
    logic [7:0] obs;
    @(negedge clk);
    obs = use4 ? v4 : v2;
    n_chk++;
    assert ((obs & msk) === (exp & msk)) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b mask=%b",
             tag, obs, exp, msk);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_lu(input logic [4:0] wa);
    id_valid     = 1'b1;
    ex_mem_rd    = 1'b1;
    ex_reg_wen   = 1'b1;
    ex_reg_waddr = wa;
    id_rs2_read  = 1'b1;
    id_rs2_addr  = 5'd5;
  endtask

  task automatic clr();
    id_valid        = 1'b0;
    id_rs1_read     = 1'b0;
    id_rs1_addr     = 5'd0;
    id_rs2_read     = 1'b0;
    id_rs2_addr     = 5'd0;
    ex_mem_rd       = 1'b0;
    ex_reg_wen      = 1'b0;
    ex_reg_waddr    = 5'd0;
    ex_branch_taken = 1'b0;
    dmem_busy       = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    cyc();
    cyc();
    chk("rst_u2", 0, 8'h00, 8'hFF);
    chk("rst_u4", 1, 8'h00, 8'hFF);
`ifdef PIPE_CTRL_PERF_EN
    chk32("perf_stall_rst", a_ps, 32'd0);
    chk32("perf_flush_rst", a_pf, 32'd0);
`endif
    rst = 1'b0;
    cyc();

    ex_branch_taken = 1'b1;
    chk("br_c0", 0, 8'h0C, 8'hFF);
    cyc();
    ex_branch_taken = 1'b0;
    chk("br_c1", 0, 8'h0E, 8'hFF);
    cyc();
    chk("br_c2", 0, 8'h00, 8'hFF);
`ifdef PIPE_CTRL_PERF_EN
    chk32("perf_flush_br", a_pf, 32'd2);
    chk32("perf_stall_br", a_ps, 32'd0);
`endif
    cyc();

    set_lu(5'd5);
    chk("lu_c0", 0, 8'hC8, 8'hFF);
    cyc();
    ex_mem_rd = 1'b0;
    chk("lu_c1", 0, 8'h00, 8'hFF);
    cyc();
    set_lu(5'd0);
    chk("lu_x0", 0, 8'h00, 8'hFF);
    cyc();
    set_lu(5'd7);
    id_rs1_read = 1'b1;
    id_rs1_addr = 5'd7;
    chk("lu_rs1", 0, 8'hC8, 8'hFF);
    cyc();
    id_valid = 1'b0;
    chk("lu_noval", 0, 8'h00, 8'hFF);
    cyc();
    clr();

    dmem_busy = 1'b1;
    chk("mw_c0", 0, 8'hF0, 8'hFF);
    cyc();
    chk("mw_c1", 0, 8'hF1, 8'hFF);
    cyc();
    chk("mw_c2", 0, 8'hF1, 8'hFF);
    cyc();
    dmem_busy = 1'b0;
    chk("mw_exit", 0, 8'h01, 8'hFF);
    cyc();
    chk("mw_run", 0, 8'h00, 8'hFF);
    cyc();

    set_lu(5'd5);
    dmem_busy       = 1'b1;
    ex_branch_taken = 1'b1;
    chk("sim_c0", 0, 8'hF0, 8'hFF);
    cyc();
    chk("sim_c1", 0, 8'hF1, 8'hFF);
    cyc();
    dmem_busy = 1'b0;
    chk("sim_drop", 0, 8'h0D, 8'hFF);
    cyc();
    ex_branch_taken = 1'b0;
    chk("sim_flush_lu", 0, 8'h0E, 8'hFF);
    cyc();
    clr();
    chk("sim_done", 0, 8'h00, 8'hFF);
    cyc();

    ex_branch_taken = 1'b1;
    chk("fb_c0", 0, 8'h0C, 8'hFF);
    cyc();
    ex_branch_taken = 1'b0;
    dmem_busy = 1'b1;
    chk("fb_busy0", 0, 8'hF6, 8'hF7);
    cyc();
    chk("fb_busy1", 0, 8'hF6, 8'hF7);
    cyc();
    dmem_busy = 1'b0;
    chk("fb_resume", 0, 8'h0E, 8'hFF);
    cyc();
    chk("fb_done", 0, 8'h00, 8'hFF);
    cyc();

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ex_branch_taken = 1'b1;
    chk("f4_c0", 1, 8'h0C, 8'hFF);
    cyc();
    ex_branch_taken = 1'b0;
    chk("f4_c1", 1, 8'h0E, 8'hFF);
    cyc();
    chk("f4_c2", 1, 8'h0E, 8'hFF);
    cyc();
    chk("f4_c3", 1, 8'h0E, 8'hFF);
    cyc();
    chk("f4_c4", 1, 8'h00, 8'hFF);
    cyc();

    ex_branch_taken = 1'b1;
    chk("rm_c0", 1, 8'h0C, 8'hFF);
    cyc();
    ex_branch_taken = 1'b0;
    rst = 1'b1;
    chk("rm_during", 1, 8'h00, 8'hFF);
    cyc();
    rst = 1'b0;
    chk("rm_after", 1, 8'h00, 8'hFF);
`ifdef PIPE_CTRL_PERF_EN
    chk32("perf_flush_rm", b_pf, 32'd0);
    chk32("perf_stall_rm", b_ps, 32'd0);
`endif
    cyc();
    chk("rm_after2", 1, 8'h00, 8'hFF);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB).
- Decides every cycle which pipeline registers hold, which take a bubble, and which are invalidated.
- Inputs: load-use hazards detected at decode, data-memory wait, and taken branches resolved in EX.
- Small FSM covers multi-cycle memory stalls and multi-cycle fetch flushes behind a synchronous instruction memory.

Parameters:
- RF_AW, 5, register-file address width.
- FLUSH_CYCLES, 2, number of cycles IF/ID is invalidated after a taken branch (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_rs1_read  in  1  decoded instruction reads rs1.
- id_rs1_addr  in  RF_AW  decoded rs1 address.
- id_rs2_read  in  1  decoded instruction reads rs2.
- id_rs2_addr  in  RF_AW  decoded rs2 address.
- ex_mem_rd  in  1  instruction in ID/EX is a load (mem_rd_op != NO_RD).
- ex_reg_wen  in  1  ID/EX register write enable.
- ex_reg_waddr  in  RF_AW  ID/EX destination register.
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- dmem_busy  in  1  data memory cannot complete the MEM-stage access this cycle.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID register.
- stall_ex  out  1  hold ID/EX register.
- stall_mem  out  1  hold EX/MEM register.
- bubble_ex  out  1  load NOP into ID/EX next edge (reg_wen=0, no mem rd/wr).
- flush_id  out  1  invalidate IF/ID next edge.
- ctrl_state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 FLUSH.

Behaviour:
- State, flush counter and perf counters are registered; all stall/bubble/flush outputs are combinational from state and inputs, valid in the same cycle.
- Reset: state=RUN, counter=0. While rst=1, all stall/bubble/flush outputs=0 and ctrl_state=0.
- Load-use hazard (lu):
  - Condition: id_valid & ex_mem_rd & ex_reg_wen & ex_reg_waddr!=0 & ((id_rs1_read & id_rs1_addr==ex_reg_waddr) | (id_rs2_read & id_rs2_addr==ex_reg_waddr)).
  - x0 never hazards.
- Priority within any state: dmem_busy > ex_branch_taken > lu.
- RUN:
  - dmem_busy=1: stall_if, stall_id, stall_ex and stall_mem all 1; bubble_ex=0; flush_id=0; next state MEM_WAIT. The branch, if any, is held in EX and not acted on.
  - else ex_branch_taken=1: flush_id=1, bubble_ex=1, no stalls. Next state FLUSH with cnt=FLUSH_CYCLES-1; if FLUSH_CYCLES==1, stay RUN.
  - else lu=1: stall_if=1, stall_id=1, bubble_ex=1; exactly one cycle, since the hazard clears when the load advances.
  - else: all outputs 0.
- MEM_WAIT:
  - All four stalls 1 while dmem_busy=1.
  - On the first cycle with dmem_busy=0, return to RUN and evaluate as RUN in the same cycle (branch/lu act immediately, no dead cycle).
- FLUSH:
  - flush_id=1, bubble_ex=1, cnt decrements each cycle; at cnt==1 the next state is RUN.
  - lu and ex_branch_taken are ignored, because ID/EX only holds bubbles.
  - dmem_busy=1 in FLUSH: all four stalls 1, flush_id=1, cnt frozen, state stays FLUSH.
- Reset mid-operation: state returns to RUN next edge, counter cleared; no residual flush or stall.
- ctrl_state encoding 3 is unreachable; if entered, go to RUN.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, add outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], both reset to 0.
  - perf_stall_cnt increments on every cycle with stall_if=1.
  - perf_flush_cnt increments on every cycle with flush_id=1.
  - Both wrap at 2^32-1 -> 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Load-use: ex_mem_rd=1, ex_reg_wen=1, ex_reg_waddr=5, id_rs2_read=1, id_rs2_addr=5 -> stall_if=stall_id=bubble_ex=1 for exactly 1 cycle. Same stimulus with waddr=0 -> all outputs 0.
- Taken branch, FLUSH_CYCLES=2: ex_branch_taken pulse -> flush_id=1 and bubble_ex=1 for 2 consecutive cycles; ctrl_state goes 0,2,0.
- Memory wait: dmem_busy high 3 cycles -> all stalls 1 for 3 cycles, ctrl_state=1 on cycles 2-3. Then 0.
- Simultaneous events: dmem_busy=1 with ex_branch_taken=1 and lu=1 -> stalls only, no flush. busy drops with branch still asserted -> flush_id=1 in that same cycle.
- Reset mid-FLUSH (FLUSH_CYCLES=4, rst at second flush cycle) -> next cycle ctrl_state=0, all outputs 0. PERF build: counters read 0 after reset, and perf_flush_cnt=2 after one FLUSH_CYCLES=2 branch.
